// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 pixel timing (hc/vc, syncs, vidon); VGA_FRAME_CNT_EN adds frame_cnt.
// Outputs are registered with zero skew to hc/vc; free-running, no backpressure.
module vga_timing_gen #(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       clr,
    output logic       pix_en,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hsync,
    output logic       vsync,
    output logic       vidon,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_MAX  = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_TOT - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    logic [3:0] div_q, div_d;
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       vidon_q, vidon_d;
    logic       frame_start_q, frame_start_d;
    logic       frame_wrap;

    // With CLK_DIV=1 DIV_MAX is 0, so the strobe is permanently high.
    assign pix_en     = (div_q == DIV_MAX);
    assign frame_wrap = pix_en && (hc_q == H_MAX) && (vc_q == V_MAX);

    always_comb begin
        div_d = pix_en ? 4'd0 : div_q + 4'd1;
        hc_d  = hc_q;
        vc_d  = vc_q;
        if (pix_en) begin
            if (hc_q == H_MAX) begin
                hc_d = 10'd0;
                vc_d = (vc_q == V_MAX) ? 10'd0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
        // Decoded from the next counts so the registered flags line up with hc/vc.
        hsync_d       = !((hc_d >= HS_START) && (hc_d < HS_END));
        vsync_d       = !((vc_d >= VS_START) && (vc_d < VS_END));
        vidon_d       = (hc_d < H_VIS_W) && (vc_d < V_VIS_W);
        frame_start_d = (hc_d == 10'd0) && (vc_d == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            div_q         <= 4'd0;
            hc_q          <= 10'd0;
            vc_q          <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            vidon_q       <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            div_q         <= div_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            vidon_q       <= vidon_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vidon       = vidon_q;
    assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_wrap ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    logic unused_frame_wrap;
    assign unused_frame_wrap = frame_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 640x480 timing at CLK_DIV=2 plus a shrunken-frame instance at CLK_DIV=1.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr_a, clr_b;
    logic       pix_en_a, hsync_a, vsync_a, vidon_a, fs_a;
    logic [9:0] hc_a, vc_a;
    logic       pix_en_b, hsync_b, vsync_b, vidon_b, fs_b;
    logic [9:0] hc_b, vc_b;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc_a, fc_b;
`endif

    int checks = 0;
    int errors = 0;

    vga_timing_gen #(.CLK_DIV(2)) dut_a (
        .clk(clk), .clr(clr_a), .pix_en(pix_en_a), .hc(hc_a), .vc(vc_a),
        .hsync(hsync_a), .vsync(vsync_a), .vidon(vidon_a), .frame_start(fs_a)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_a)
`endif
    );

    // Small frame: H_TOT=16 (hsync low 10..12), V_TOT=13 (vsync low 8..9), 208 clk per frame.
    vga_timing_gen #(
        .CLK_DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_b (
        .clk(clk), .clr(clr_b), .pix_en(pix_en_b), .hc(hc_b), .vc(vc_b),
        .hsync(hsync_b), .vsync(vsync_b), .vidon(vidon_b), .frame_start(fs_b)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_b)
`endif
    );

    task automatic test_reset();
        clr_a = 1'b0;
        clr_b = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (hc_a !== 10'd0) begin errors++; $display("FAIL reset_hc: got %0d expected 0", hc_a); end
        checks++; if (vc_a !== 10'd0) begin errors++; $display("FAIL reset_vc: got %0d expected 0", vc_a); end
        checks++; if (hsync_a !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", hsync_a); end
        checks++; if (vsync_a !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", vsync_a); end
        checks++; if (vidon_a !== 1'b1) begin errors++; $display("FAIL reset_vidon: got %b expected 1", vidon_a); end
        checks++; if (fs_a !== 1'b1) begin errors++; $display("FAIL reset_frame_start: got %b expected 1", fs_a); end
        checks++; if (pix_en_a !== 1'b0) begin errors++; $display("FAIL reset_pix_en: got %b expected 0", pix_en_a); end
        checks++; if (hc_b !== 10'd0 || vc_b !== 10'd0) begin errors++; $display("FAIL reset_b_hcvc: got %0d,%0d expected 0,0", hc_b, vc_b); end
`ifdef VGA_FRAME_CNT_EN
        checks++; if (fc_a !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", fc_a); end
`endif
    endtask

    task automatic test_line_timing();
        int fall_t = -1, fall_hc = -1, rise_t = -1, rise_hc = -1;
        int wrap1 = -1, wrap2 = -1, pre_vc = -1, post_vc = -1;
        int prev_hc = 0, prev_vc = 0;
        logic prev_hs = 1'b1;
        logic pe0 = 1'bx, pe1 = 1'bx, v639 = 1'bx, v640 = 1'bx;
        int hc2 = -1;
        clr_a = 1'b1;
        for (int t = 0; t < 3300; t++) begin
            if (t > 0) @(negedge clk);
            if (t == 0) pe0 = pix_en_a;
            if (t == 1) pe1 = pix_en_a;
            if (t == 2) hc2 = int'(hc_a);
            if (prev_hs && !hsync_a && fall_t < 0) begin fall_t = t; fall_hc = int'(hc_a); end
            if (!prev_hs && hsync_a && rise_t < 0) begin rise_t = t; rise_hc = int'(hc_a); end
            if (t > 0 && hc_a == 10'd0 && prev_hc == 799) begin
                if (wrap1 < 0) begin wrap1 = t; pre_vc = prev_vc; post_vc = int'(vc_a); end
                else if (wrap2 < 0) wrap2 = t;
            end
            if (hc_a == 10'd639 && vc_a == 10'd0) v639 = vidon_a;
            if (hc_a == 10'd640 && vc_a == 10'd0) v640 = vidon_a;
            prev_hs = hsync_a;
            prev_hc = int'(hc_a);
            prev_vc = int'(vc_a);
        end
        checks++; if (pe0 !== 1'b0) begin errors++; $display("FAIL release_pix_en_c1: got %b expected 0", pe0); end
        checks++; if (pe1 !== 1'b1) begin errors++; $display("FAIL release_pix_en_c2: got %b expected 1", pe1); end
        checks++; if (hc2 != 1) begin errors++; $display("FAIL release_hc_after_2: got %0d expected 1", hc2); end
        checks++; if (fall_hc != 656 || fall_t != 1312) begin errors++; $display("FAIL hsync_fall: got hc %0d t %0d expected hc 656 t 1312", fall_hc, fall_t); end
        checks++; if (rise_hc != 752 || rise_t != 1504) begin errors++; $display("FAIL hsync_rise: got hc %0d t %0d expected hc 752 t 1504", rise_hc, rise_t); end
        checks++; if (wrap1 != 1600 || pre_vc != 0 || post_vc != 1) begin errors++; $display("FAIL line_wrap: got t %0d vc %0d->%0d expected t 1600 vc 0->1", wrap1, pre_vc, post_vc); end
        checks++; if (wrap2 - wrap1 != 1600) begin errors++; $display("FAIL line_period: got %0d expected 1600", wrap2 - wrap1); end
        checks++; if (v639 !== 1'b1) begin errors++; $display("FAIL vidon_639_0: got %b expected 1", v639); end
        checks++; if (v640 !== 1'b0) begin errors++; $display("FAIL vidon_640_0: got %b expected 0", v640); end
    endtask

    task automatic test_mid_frame_reset();
        bit found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            if (hc_a == 10'd300 && vc_a == 10'd2) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL midreset_reach: got timeout expected hc 300 vc 2"); end
        clr_a = 1'b0;
        @(negedge clk);
        checks++; if (hc_a !== 10'd0 || vc_a !== 10'd0) begin errors++; $display("FAIL midreset_hcvc: got %0d,%0d expected 0,0", hc_a, vc_a); end
        checks++; if (pix_en_a !== 1'b0 || fs_a !== 1'b1) begin errors++; $display("FAIL midreset_pe_fs: got %b,%b expected 0,1", pix_en_a, fs_a); end
        clr_a = 1'b1;
        checks++; if (pix_en_a !== 1'b0) begin errors++; $display("FAIL midreset_pe_c1: got %b expected 0", pix_en_a); end
        @(negedge clk);
        checks++; if (pix_en_a !== 1'b1 || hc_a !== 10'd0) begin errors++; $display("FAIL midreset_pe_c2: got pe %b hc %0d expected pe 1 hc 0", pix_en_a, hc_a); end
        @(negedge clk);
        checks++; if (hc_a !== 10'd1 || pix_en_a !== 1'b0) begin errors++; $display("FAIL midreset_hc1: got hc %0d pe %b expected hc 1 pe 0", hc_a, pix_en_a); end
    endtask

    task automatic test_frame_timing();
        int pe_low = 0, step_err = 0, vs_low = 0, vs_min = 99, vs_max = -1, fs_cnt = 0;
        int wrap1 = -1, wrap2 = -1, pre_hc = -1, pre_vc = -1;
        int prev_hc = 0, prev_vc = 0;
        logic fs_wrap = 1'bx, v_a = 1'bx, v_b = 1'bx, v_c = 1'bx, v_d = 1'bx;
`ifdef VGA_FRAME_CNT_EN
        int fc0 = -1, fc1 = -1;
`endif
        clr_b = 1'b1;
        for (int t = 0; t < 420; t++) begin
            if (t > 0) @(negedge clk);
            if (!pix_en_b) pe_low++;
            if (t > 0 && int'(hc_b) != (prev_hc + 1) % 16) step_err++;
            if (t < 208) begin
                if (!vsync_b) begin
                    vs_low++;
                    if (int'(vc_b) < vs_min) vs_min = int'(vc_b);
                    if (int'(vc_b) > vs_max) vs_max = int'(vc_b);
                end
                if (fs_b) fs_cnt++;
            end
            if (t > 0 && hc_b == 10'd0 && vc_b == 10'd0) begin
                if (wrap1 < 0) begin wrap1 = t; pre_hc = prev_hc; pre_vc = prev_vc; fs_wrap = fs_b; end
                else if (wrap2 < 0) wrap2 = t;
            end
            if (hc_b == 10'd7 && vc_b == 10'd5) v_a = vidon_b;
            if (hc_b == 10'd8 && vc_b == 10'd0) v_b = vidon_b;
            if (hc_b == 10'd0 && vc_b == 10'd6) v_c = vidon_b;
            if (hc_b == 10'd15 && vc_b == 10'd12) v_d = vidon_b;
`ifdef VGA_FRAME_CNT_EN
            if (t == 0) fc0 = int'(fc_b);
            if (t == 208) fc1 = int'(fc_b);
`endif
            prev_hc = int'(hc_b);
            prev_vc = int'(vc_b);
        end
        checks++; if (pe_low != 0) begin errors++; $display("FAIL div1_pix_en_low: got %0d cycles expected 0", pe_low); end
        checks++; if (step_err != 0) begin errors++; $display("FAIL div1_hc_step: got %0d bad steps expected 0", step_err); end
        checks++; if (vs_low != 32 || vs_min != 8 || vs_max != 9) begin errors++; $display("FAIL vsync_window: got %0d clk vc %0d..%0d expected 32 clk vc 8..9", vs_low, vs_min, vs_max); end
        checks++; if (wrap1 != 208 || pre_hc != 15 || pre_vc != 12) begin errors++; $display("FAIL frame_wrap: got t %0d from %0d,%0d expected t 208 from 15,12", wrap1, pre_hc, pre_vc); end
        checks++; if (fs_wrap !== 1'b1 || fs_cnt != 1) begin errors++; $display("FAIL frame_start: got wrap %b count %0d expected 1 count 1", fs_wrap, fs_cnt); end
        checks++; if (wrap2 - wrap1 != 208) begin errors++; $display("FAIL frame_period: got %0d expected 208", wrap2 - wrap1); end
        checks++; if (v_a !== 1'b1) begin errors++; $display("FAIL vidon_last_visible: got %b expected 1", v_a); end
        checks++; if (v_b !== 1'b0) begin errors++; $display("FAIL vidon_h_edge: got %b expected 0", v_b); end
        checks++; if (v_c !== 1'b0) begin errors++; $display("FAIL vidon_v_edge: got %b expected 0", v_c); end
        checks++; if (v_d !== 1'b0) begin errors++; $display("FAIL vidon_last_pixel: got %b expected 0", v_d); end
`ifdef VGA_FRAME_CNT_EN
        checks++; if (fc0 != 0 || fc1 != 1) begin errors++; $display("FAIL frame_cnt_first: got %0d,%0d expected 0,1", fc0, fc1); end
`endif
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_cnt_wrap();
        bit found = 1'b0;
        for (int i = 0; i < 60000 && !found; i++) begin
            if (fc_b == 8'd255 && hc_b == 10'd15 && vc_b == 10'd12) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL frame_cnt_reach: got timeout expected frame_cnt 255 at end of frame"); end
        @(negedge clk);
        checks++; if (fc_b !== 8'd0 || hc_b !== 10'd0 || vc_b !== 10'd0) begin errors++; $display("FAIL frame_cnt_wrap: got cnt %0d at %0d,%0d expected 0 at 0,0", fc_b, hc_b, vc_b); end
    endtask
`endif

    initial begin
        test_reset();
        test_line_timing();
        test_mid_frame_reset();
        test_frame_timing();
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing generator for the 640x480@60 Hz display path.
- Produces horizontal/vertical pixel coordinates, sync pulses and a video-on flag.
- Sits directly upstream of the character-cell block-address counter, which consumes hc/vc and forms blk_addr = 80*vc[9:3] + hc[9:3].
- hc/vc are active-area-relative: visible pixels are hc 0..639, vc 0..479. No porch offset is applied.

Parameters:
CLK_DIV, 2, system clocks per pixel (2 gives 25 MHz from 50 MHz); legal range 1..16
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VIS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  input  1  system clock; all logic on the rising edge
clr  input  1  reset, synchronous, active-low (clr=0 resets on the next rising clk)
pix_en  output  1  pixel-rate strobe; high on the clk cycle at whose end hc/vc advance
hc  output  10  horizontal pixel count, 0..H_TOT-1
vc  output  10  vertical line count, 0..V_TOT-1
hsync  output  1  horizontal sync, active-low
vsync  output  1  vertical sync, active-low
vidon  output  1  high when (hc,vc) lies in the visible area
frame_start  output  1  high while hc=0 and vc=0

Behaviour:
- H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800). V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525). Both must be at most 1024.
- Divider div counts 0..CLK_DIV-1 and wraps. pix_en = (div==CLK_DIV-1), combinational from div. With CLK_DIV=1, pix_en is constantly 1 out of reset.
- On a clk edge with pix_en=1:
  - If hc==H_TOT-1: hc<=0; vc<=(vc==V_TOT-1) ? 0 : vc+1.
  - Otherwise: hc<=hc+1 and vc holds.
- hsync, vsync, vidon and frame_start are registered. Each is computed from the next hc/vc values, so it is aligned to the same cycle as the hc/vc it describes (zero skew).
  - hsync=0 iff H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC (656..751).
  - vsync=0 iff V_VIS+V_FP <= vc < V_VIS+V_FP+V_SYNC (490..491).
  - vidon=1 iff hc<H_VIS and vc<V_VIS.
- Reset (clr=0 at a rising clk) takes priority over everything, including mid-line or mid-frame:
  - div=0, hc=0, vc=0, hsync=1, vsync=1, vidon=1, frame_start=1.
  - pix_en=0 while in reset when CLK_DIV>1.
  - Outputs describe pixel (0,0) during reset and afterwards.
- After clr returns to 1: the first pix_en occurs CLK_DIV clk cycles later (on cycle CLK_DIV, counting the first released cycle as 1). Pixel (0,0) is therefore held for exactly CLK_DIV cycles.
- Counters never exceed H_TOT-1 / V_TOT-1. No illegal states are reachable.
- Latency to the downstream address counter is 0: hc/vc are valid registered outputs for the whole pixel period.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt [7:0], reset to 0.
  - Increments on the pix_en edge where hc wraps H_TOT-1→0 and vc wraps V_TOT-1→0.
  - Wraps 255→0. Used for cursor blink.
- Not defined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset: clr=0 for 5 clk with CLK_DIV=2 → hc=0, vc=0, hsync=1, vsync=1, vidon=1, frame_start=1, pix_en=0.
- Line timing (CLK_DIV=2, release reset):
  - hsync falls on the cycle hc becomes 656 and rises when hc becomes 752.
  - hc wraps 799→0 with vc 0→1.
  - Line period is 1600 clk.
- Frame timing:
  - vsync is low exactly while vc is 490 or 491 (3200 clk).
  - vc wraps 524→0 and frame_start reasserts.
  - Frame period is 840000 clk.
- Visible window: (hc=639, vc=479) → vidon=1; (640,0) → 0; (0,480) → 0; (799,524) → 0.
- Mid-frame reset:
  - Drive clr=0 for one clk at hc=300, vc=200 → next edge gives hc=0, vc=0, div=0.
  - First pix_en comes on the 2nd clk after release; hc=1 after the 2nd edge.
- CLK_DIV=1 build: pix_en stays high after reset and hc increments every clk. With VGA_FRAME_CNT_EN, frame_cnt=1 after 420000 clk and wraps 255→0 after 256 frames.
